// File: rtl/tc77_responder.sv
// rtl/tc77_responder.sv - TC77-style serial temperature sensor responder
//
// Purpose:
//   Emulates a TC77 temperature sensor on a 3-wire bus.
//   - A free-running conversion timer periodically latches TEMPVAL.
//   - A host transaction starts on the nCS fall. It reads a 16-bit frame
//     {temp[12:0], convdone, 2'b00} and then may shift in a 16-bit
//     config word.
//   - Config word 16'hFFFF enters shutdown; 16'h0000 leaves it.
//
// Ports:
//   MCLK      in   sole clock, rising edge
//   RESET     in   synchronous, active-high reset
//   nCS       in   host chip select, active-low, asynchronous
//   SCK       in   host serial clock, asynchronous, idles low
//   SIO_IN    in   sampled level of the SIO pad
//   SIO_OUT   out  data driven onto SIO (1 whenever SIO_OE=0)
//   SIO_OE    out  SIO pad output enable, 1=drive
//   TEMPVAL   in   13-bit signed temperature, 0.0625 C/LSB
//   SHUTDOWN  out  emulated sensor shutdown flag
//   CONVDONE  out  at least one conversion completed since reset
//   nCFGSTB   out  one-cycle active-low strobe on a complete config word
//   CFGWORD   out  last complete config word

module tc77_responder #(
  parameter logic [23:0] CONV_CYCLES = 24'd1000
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        nCS,
  input  logic        SCK,
  input  logic        SIO_IN,
  output logic        SIO_OUT,
  output logic        SIO_OE,
  input  logic [12:0] TEMPVAL,
  output logic        SHUTDOWN,
  output logic        CONVDONE,
  output logic        nCFGSTB,
  output logic [15:0] CFGWORD
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    WAITCS = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  // Synchronizers plus one delay flop each for edge detection.
  logic        r_ncs_s1, r_ncs_s2, r_ncs_d;
  logic        r_sck_s1, r_sck_s2, r_sck_d;
  logic        r_sio_s1, r_sio_s2;

  // r_ncs_s2/r_ncs_d hold reset values, not pad samples, for the first
  // few cycles after reset. r_warm waits those cycles out. r_armed then
  // requires a genuine high level on nCS before a fall can start a
  // transaction, so a chip select already low at reset release is ignored.
  logic [1:0]  r_warm;
  logic        r_armed;

  logic [15:0] r_shift_out;
  logic [3:0]  r_bitcnt;
  logic        r_sio_oe;
  logic [15:0] r_cfg_shift;
  logic [15:0] r_cfgword;
  logic        r_ncfgstb;
  logic        r_shutdown;
  logic        r_convdone;
  logic [12:0] r_temp;
  logic [23:0] r_conv_cnt;

  logic        w_ncs_fall;
  logic        w_ncs_rise;
  logic        w_sck_rise;
  logic        w_sck_fall;
  logic        w_conv_wrap;
  logic        w_cnt_last;
  logic [15:0] w_cfg_next;

  logic        w_load;
  logic        w_rd_shift;
  logic        w_cnt_inc;
  logic        w_cfg_shift;
  logic        w_cfg_done;
  logic        w_abort;

  assign w_ncs_fall  = r_ncs_d & ~r_ncs_s2 & r_armed;
  assign w_ncs_rise  = ~r_ncs_d & r_ncs_s2;
  assign w_sck_rise  = ~r_sck_d & r_sck_s2;
  assign w_sck_fall  = r_sck_d & ~r_sck_s2;
  assign w_conv_wrap = ~r_shutdown & (r_conv_cnt == (CONV_CYCLES - 24'd1));
  assign w_cnt_last  = (r_bitcnt == 4'd15);
  assign w_cfg_next  = {r_cfg_shift[14:0], r_sio_s2};

  // ---------------------------------------------------------------------
  // Input synchronization
  // ---------------------------------------------------------------------
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_ncs_s1 <= 1'b1;
      r_ncs_s2 <= 1'b1;
      r_ncs_d  <= 1'b1;
      r_sck_s1 <= 1'b0;
      r_sck_s2 <= 1'b0;
      r_sck_d  <= 1'b0;
      r_sio_s1 <= 1'b0;
      r_sio_s2 <= 1'b0;
      r_warm   <= 2'd0;
      r_armed  <= 1'b0;
    end else begin
      r_ncs_s1 <= nCS;
      r_ncs_s2 <= r_ncs_s1;
      r_ncs_d  <= r_ncs_s2;
      r_sck_s1 <= SCK;
      r_sck_s2 <= r_sck_s1;
      r_sck_d  <= r_sck_s2;
      r_sio_s1 <= SIO_IN;
      r_sio_s2 <= r_sio_s1;
      if (r_warm != 2'd3) begin
        r_warm <= r_warm + 2'd1;
      end else if (r_ncs_s2 && r_ncs_d) begin
        r_armed <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and datapath strobes
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_rd_shift   = 1'b0;
    w_cnt_inc    = 1'b0;
    w_cfg_shift  = 1'b0;
    w_cfg_done   = 1'b0;
    w_abort      = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_ncs_fall) begin
          w_load       = 1'b1;
          w_state_next = READ;
        end
      end
      READ: begin
        if (w_sck_rise) begin
          w_cnt_inc = 1'b1;
          // The 4-bit counter wraps to zero here, so it is already
          // cleared for the write phase.
          if (w_cnt_last) begin
            w_state_next = WRITE;
          end
        end
        if (w_sck_fall) begin
          w_rd_shift = 1'b1;
        end
      end
      WRITE: begin
        if (w_sck_rise) begin
          w_cnt_inc   = 1'b1;
          w_cfg_shift = 1'b1;
          if (w_cnt_last) begin
            w_cfg_done   = 1'b1;
            w_state_next = WAITCS;
          end
        end
      end
      WAITCS: begin
        w_state_next = WAITCS;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // A chip-select release overrides everything. A partial frame or a
    // partial config word is dropped.
    if (w_ncs_rise) begin
      w_state_next = IDLE;
      w_load       = 1'b0;
      w_rd_shift   = 1'b0;
      w_cnt_inc    = 1'b0;
      w_cfg_shift  = 1'b0;
      w_cfg_done   = 1'b0;
      w_abort      = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_shift_out <= 16'h0000;
      r_bitcnt    <= 4'd0;
      r_sio_oe    <= 1'b0;
      r_cfg_shift <= 16'h0000;
      r_cfgword   <= 16'h0000;
      r_ncfgstb   <= 1'b1;
      r_shutdown  <= 1'b0;
      r_convdone  <= 1'b0;
      r_temp      <= 13'd0;
      r_conv_cnt  <= 24'd0;
    end else begin
      // Conversion timer. It is frozen in shutdown. A wrap only updates
      // r_temp; a frame already loaded is unaffected, and a load in the
      // same cycle still sees the pre-wrap values.
      if (!r_shutdown) begin
        if (w_conv_wrap) begin
          r_conv_cnt <= 24'd0;
          r_temp     <= TEMPVAL;
          r_convdone <= 1'b1;
        end else begin
          r_conv_cnt <= r_conv_cnt + 24'd1;
        end
      end

      r_ncfgstb <= ~w_cfg_done;

      if (w_load) begin
        r_shift_out <= {r_temp, r_convdone, 2'b00};
        r_sio_oe    <= 1'b1;
        r_bitcnt    <= 4'd0;
      end

      // Fall k presents frame bit 15-k. Fall 13 presents bit 2
      // (CONVDONE), which the host samples on the 14th rise. The pad is
      // released on the next fall, so bits 1:0 are never driven.
      if (w_rd_shift) begin
        r_shift_out <= {r_shift_out[14:0], 1'b0};
        if (r_bitcnt >= 4'd14) begin
          r_sio_oe <= 1'b0;
        end
      end

      if (w_cnt_inc) begin
        r_bitcnt <= r_bitcnt + 4'd1;
      end

      if (w_cfg_shift) begin
        r_cfg_shift <= w_cfg_next;
      end

      if (w_cfg_done) begin
        r_cfgword <= w_cfg_next;
        if (w_cfg_next == 16'hFFFF) begin
          r_shutdown <= 1'b1;
        end else if (w_cfg_next == 16'h0000) begin
          r_shutdown <= 1'b0;
        end
      end

      if (w_abort) begin
        r_sio_oe <= 1'b0;
      end
    end
  end

  assign SIO_OE   = r_sio_oe;
  assign SIO_OUT  = r_sio_oe ? r_shift_out[15] : 1'b1;
  assign SHUTDOWN = r_shutdown;
  assign CONVDONE = r_convdone;
  assign nCFGSTB  = r_ncfgstb;
  assign CFGWORD  = r_cfgword;

endmodule

// File: tb/tb_tc77_responder.sv
// tb/tb_tc77_responder.sv - directed self-checking bench for tc77_responder

module tb_tc77_responder;

  logic        MCLK = 1'b0;
  logic        RESET;
  logic        nCS;
  logic        SCK;
  logic        SIO_IN;
  logic        SIO_OUT;
  logic        SIO_OE;
  logic [12:0] TEMPVAL;
  logic        SHUTDOWN;
  logic        CONVDONE;
  logic        nCFGSTB;
  logic [15:0] CFGWORD;

  int checks   = 0;
  int failures = 0;
  int strobes  = 0;

  tc77_responder #(.CONV_CYCLES(24'd1000)) dut (
    .MCLK     (MCLK),
    .RESET    (RESET),
    .nCS      (nCS),
    .SCK      (SCK),
    .SIO_IN   (SIO_IN),
    .SIO_OUT  (SIO_OUT),
    .SIO_OE   (SIO_OE),
    .TEMPVAL  (TEMPVAL),
    .SHUTDOWN (SHUTDOWN),
    .CONVDONE (CONVDONE),
    .nCFGSTB  (nCFGSTB),
    .CFGWORD  (CFGWORD)
  );

  always #5 MCLK = ~MCLK;

  always @(negedge MCLK) begin
    if (nCFGSTB === 1'b0) strobes++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge MCLK);
  endtask

  // Host transaction. SCK phases are 6 MCLK each.
  // - Read bits are sampled just before each rise; an undriven pad reads 0.
  // - oe_tail records SIO_OE before rises 14, 15 and 16.
  // - Write bits (clocks 17..32) come from wdata, MSB first.
  task automatic xfer(input int n_clk, input logic [15:0] wdata, input bit end_cs,
                      output logic [15:0] rdata, output logic [2:0] oe_tail);
    rdata   = 16'h0000;
    oe_tail = 3'b000;
    nCS     = 1'b0;
    for (int i = 0; i < n_clk; i++) begin
      if (i >= 16) SIO_IN = wdata[15 - (i - 16)];
      else         SIO_IN = 1'b0;
      cyc(6);
      if (i < 16) rdata[15 - i] = SIO_OE ? SIO_OUT : 1'b0;
      if (i >= 13 && i <= 15) oe_tail[i - 13] = SIO_OE;
      SCK = 1'b1;
      cyc(6);
      SCK = 1'b0;
    end
    if (end_cs) begin
      cyc(6);
      nCS = 1'b1;
      cyc(10);
    end
  endtask

  initial begin
    logic [15:0] rd;
    logic [2:0]  tail;
    int          s0;

    RESET   = 1'b1;
    nCS     = 1'b1;
    SCK     = 1'b0;
    SIO_IN  = 1'b0;
    TEMPVAL = 13'h0190;
    cyc(3);
    check("rst_oe",       {31'd0, SIO_OE},   32'd0);
    check("rst_out",      {31'd0, SIO_OUT},  32'd1);
    check("rst_shutdown", {31'd0, SHUTDOWN}, 32'd0);
    check("rst_convdone", {31'd0, CONVDONE}, 32'd0);
    check("rst_ncfgstb",  {31'd0, nCFGSTB},  32'd1);
    check("rst_cfgword",  {16'd0, CFGWORD},  32'h0000);
    RESET = 1'b0;
    cyc(10);

    // Read before the first conversion.
    xfer(16, 16'h0000, 1'b1, rd, tail);
    check("read_preconv", {16'd0, rd}, 32'h0000);
    check("oe_tail_pre",  {29'd0, tail}, 32'd1);

    // +25.0 C after a conversion.
    cyc(1010);
    check("convdone_set", {31'd0, CONVDONE}, 32'd1);
    xfer(16, 16'h0000, 1'b1, rd, tail);
    check("read_25c",     {16'd0, rd}, 32'h0C84);
    check("oe_tail_25c",  {29'd0, tail}, 32'd1);

    // -1.0 C.
    TEMPVAL = 13'h1FF0;
    cyc(1010);
    xfer(16, 16'h0000, 1'b1, rd, tail);
    check("read_neg1c", {16'd0, rd}, 32'hFF84);

    // Enter shutdown.
    s0 = strobes;
    xfer(32, 16'hFFFF, 1'b1, rd, tail);
    check("read_before_sd", {16'd0, rd}, 32'hFF84);
    check("strobe_sd",      strobes - s0, 32'd1);
    check("shutdown_set",   {31'd0, SHUTDOWN}, 32'd1);
    check("cfgword_ffff",   {16'd0, CFGWORD}, 32'hFFFF);

    // Shutdown freezes the reported temperature.
    TEMPVAL = 13'h0190;
    cyc(1010);
    xfer(16, 16'h0000, 1'b1, rd, tail);
    check("read_sd_hold", {16'd0, rd}, 32'hFF84);

    // Resume.
    s0 = strobes;
    xfer(32, 16'h0000, 1'b1, rd, tail);
    check("strobe_resume",  strobes - s0, 32'd1);
    check("shutdown_clr",   {31'd0, SHUTDOWN}, 32'd0);
    check("cfgword_0000",   {16'd0, CFGWORD}, 32'h0000);
    cyc(1010);
    xfer(16, 16'h0000, 1'b1, rd, tail);
    check("read_resumed", {16'd0, rd}, 32'h0C84);

    // Non-special config word leaves shutdown alone.
    xfer(32, 16'hA5C3, 1'b1, rd, tail);
    check("cfgword_a5c3",   {16'd0, CFGWORD}, 32'hA5C3);
    check("shutdown_a5c3",  {31'd0, SHUTDOWN}, 32'd0);

    // Abort after 8 read clocks.
    xfer(8, 16'h0000, 1'b0, rd, tail);
    check("abort_rd_bits", {24'd0, rd[15:8]}, 32'h0C);
    check("abort_rd_oe_before", {31'd0, SIO_OE}, 32'd1);
    nCS = 1'b1;
    cyc(3);
    check("abort_rd_oe",  {31'd0, SIO_OE},  32'd0);
    check("abort_rd_out", {31'd0, SIO_OUT}, 32'd1);
    cyc(10);

    // Abort after 10 write clocks.
    s0 = strobes;
    xfer(26, 16'hFFFF, 1'b0, rd, tail);
    nCS = 1'b1;
    cyc(10);
    check("abort_wr_strobe",   strobes - s0, 32'd0);
    check("abort_wr_cfgword",  {16'd0, CFGWORD}, 32'hA5C3);
    check("abort_wr_shutdown", {31'd0, SHUTDOWN}, 32'd0);
    xfer(16, 16'h0000, 1'b1, rd, tail);
    check("read_after_abort", {16'd0, rd}, 32'h0C84);

    // Reset during read bit 5.
    nCS = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(6);
      SCK = 1'b1;
      cyc(6);
      SCK = 1'b0;
    end
    RESET = 1'b1;
    cyc(1);
    check("midrst_oe",       {31'd0, SIO_OE},   32'd0);
    check("midrst_out",      {31'd0, SIO_OUT},  32'd1);
    check("midrst_shutdown", {31'd0, SHUTDOWN}, 32'd0);
    check("midrst_convdone", {31'd0, CONVDONE}, 32'd0);
    check("midrst_ncfgstb",  {31'd0, nCFGSTB},  32'd1);
    check("midrst_cfgword",  {16'd0, CFGWORD},  32'h0000);
    cyc(2);
    RESET = 1'b0;
    cyc(20);
    check("no_start_cs_low", {31'd0, SIO_OE}, 32'd0);
    nCS = 1'b1;
    cyc(10);
    xfer(16, 16'h0000, 1'b1, rd, tail);
    check("read_after_rst", {16'd0, rd}, 32'h0000);
    check("oe_tail_rst",    {29'd0, tail}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
